// File: rtl/mcp4921_spi_tx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mcp49xx_pkg
//  Description : Shared definitions for the MCP4921/4922 DAC transmitter:
//                FSM state encodings, config-nibble bit positions, frame
//                length and a frame-packing helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mcp49xx_pkg;

    localparam int FRAME_BITS = 16;

    // Bit positions inside the 4-bit config nibble {A/B, BUF, GA_n, SHDN_n}
    localparam int CFG_AB     = 3;
    localparam int CFG_BUF    = 2;
    localparam int CFG_GA_N   = 1;
    localparam int CFG_SHDN_N = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        LDAC  = 3'd4,
        GAP   = 3'd5
    } state_t;

    // Command word as the DAC expects it: config nibble on top, code below.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [3:0]  cfg,
                                                         input logic [11:0] data);
        return {cfg[CFG_AB], cfg[CFG_BUF], cfg[CFG_GA_N], cfg[CFG_SHDN_N], data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcp4921_spi_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mcp4921_spi_tx_if
//  Description : Start/busy/done handshake between a sample producer and
//                the MCP4921 transmitter.
//                  start   : request a frame (producer -> tx)
//                  data_in : 12-bit DAC code (producer -> tx)
//                  cfg_in  : {A/B, BUF, GA_n, SHDN_n} (producer -> tx)
//                  busy    : frame in progress (tx -> producer)
//                  done    : one-cycle completion pulse (tx -> producer)
//  Revision    : 1.0  initial release
// ============================================================================
interface mcp4921_spi_tx_if;
    import mcp49xx_pkg::*;

    logic                  start;
    logic [FRAME_BITS-5:0] data_in;
    logic [3:0]            cfg_in;
    logic                  busy;
    logic                  done;

    modport master (output start, data_in, cfg_in, input  busy, done);
    modport slave  (input  start, data_in, cfg_in, output busy, done);

endinterface
`default_nettype wire

// File: rtl/mcp4921_spi_tx_clk_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_clk_div
//  Description : SPI phase-tick generator. While en is high, tick pulses on
//                the last clk cycle of every CLK_DIV-cycle phase. Dropping en
//                (or taking a tick) reloads the counter so the next phase is
//                a full CLK_DIV cycles.
//  Ports       : clk  - system clock
//                rst  - synchronous reset, active-low
//                en   - count enable (phase in progress)
//                tick - last cycle of the current phase
//  Revision    : 1.0  initial release
// ============================================================================
module spi_clk_div #(
    parameter int CLK_DIV = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    output logic      tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/mcp4921_spi_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mcp4921_spi_tx
//  Description : Write-only SPI master (mode 0,0) for the MCP4921/4922 DAC.
//                Latches a 12-bit code plus 4 config bits on an accepted
//                start and shifts one 16-bit frame out MSB first.
//                Sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP [-> LDAC]
//                -> IDLE, each non-SHIFT phase lasting CLK_DIV cycles and
//                each SCK half-period lasting CLK_DIV cycles.
//  Config      : `define MCP4921_LDAC_EN to drive an LDAC_n strobe after the
//                frame; otherwise dac_ldac_pin is tied low.
//  Ports       : clk          - system clock
//                rst          - synchronous reset, active-low
//                bus          - start/data/cfg in, busy/done out (slave)
//                dac_cs_pin   - chip select, active-low
//                dac_clk_pin  - SCK, idles low
//                dac_mosi_pin - serial data, MSB first
//                dac_ldac_pin - LDAC_n
//  Revision    : 1.0  initial release
// ============================================================================
module mcp4921_spi_tx
    import mcp49xx_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mcp4921_spi_tx_if.slave  bus,
    output logic             dac_cs_pin,
    output logic             dac_clk_pin,
    output logic             dac_mosi_pin,
    output logic             dac_ldac_pin
);

    state_t                  state;
    state_t                  state_nxt;
    logic                    tick;
    logic                    sck_hi;     // SCK level within the current bit
    logic [4:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   sreg;
    logic                    done_q;
    logic                    last_bit;

    assign last_bit = (bit_cnt == 5'(FRAME_BITS - 1));

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // State register and completion pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state != IDLE) && (state_nxt == IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start)                  state_nxt = SETUP;
            SETUP: if (tick)                       state_nxt = SHIFT;
            SHIFT: if (tick && sck_hi && last_bit) state_nxt = HOLD;
            HOLD:  if (tick)                       state_nxt = GAP;
`ifdef MCP4921_LDAC_EN
            // The strobe follows a full CS-high gap so LDAC_n never falls
            // too close to the CS rising edge; done follows the strobe.
            GAP:   if (tick)                       state_nxt = LDAC;
            LDAC:  if (tick)                       state_nxt = IDLE;
`else
            GAP:   if (tick)                       state_nxt = IDLE;
`endif
            default:                               state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register, bit counter and SCK phase
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
            sck_hi  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sreg    <= make_frame(bus.cfg_in, bus.data_in);
                        bit_cnt <= '0;
                        sck_hi  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sck_hi) begin
                            sck_hi <= 1'b1;
                        end else begin
                            sck_hi <= 1'b0;
                            // Next bit is presented as SCK falls; the final
                            // bit stays on MOSI through HOLD.
                            if (!last_bit) begin
                                bit_cnt <= bit_cnt + 5'd1;
                                sreg    <= {sreg[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        dac_cs_pin   = 1'b1;
        dac_mosi_pin = 1'b0;
        case (state)
            SETUP, SHIFT, HOLD: begin
                dac_cs_pin   = 1'b0;
                dac_mosi_pin = sreg[FRAME_BITS-1];
            end
            default: ;
        endcase
        dac_clk_pin  = (state == SHIFT) && sck_hi;
`ifdef MCP4921_LDAC_EN
        dac_ldac_pin = (state != LDAC);
`else
        dac_ldac_pin = 1'b0;
`endif
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp4921_spi_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mcp4921_spi_tx
//  Description : Directed self-checking bench for mcp4921_spi_tx. Three DUTs
//                (CLK_DIV = 1, 4, 2) share clock and reset; a negedge
//                monitor rebuilds the shifted word from SCK rises and
//                measures SCK phase lengths.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcp4921_spi_tx;

    localparam int DIVS [3] = '{1, 4, 2};
`ifdef MCP4921_LDAC_EN
    localparam int   LAT_K     = 36;
    localparam logic LDAC_IDLE = 1'b1;
`else
    localparam int   LAT_K     = 35;
    localparam logic LDAC_IDLE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  start_v = 3'b111;
    logic [11:0] data_v [3] = '{12'hFFF, 12'hFFF, 12'hFFF};
    logic [3:0]  cfg_v  [3] = '{4'hF, 4'hF, 4'hF};

    wire  [2:0]  cs_w, sck_w, mosi_w, ldac_w, busy_w, done_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mcp4921_spi_tx_if bus0 ();
    mcp4921_spi_tx_if bus1 ();
    mcp4921_spi_tx_if bus2 ();

    assign bus0.start = start_v[0];  assign bus0.data_in = data_v[0];  assign bus0.cfg_in = cfg_v[0];
    assign bus1.start = start_v[1];  assign bus1.data_in = data_v[1];  assign bus1.cfg_in = cfg_v[1];
    assign bus2.start = start_v[2];  assign bus2.data_in = data_v[2];  assign bus2.cfg_in = cfg_v[2];
    assign busy_w = {bus2.busy, bus1.busy, bus0.busy};
    assign done_w = {bus2.done, bus1.done, bus0.done};

    mcp4921_spi_tx #(.CLK_DIV(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0),
        .dac_cs_pin(cs_w[0]), .dac_clk_pin(sck_w[0]), .dac_mosi_pin(mosi_w[0]), .dac_ldac_pin(ldac_w[0]));
    mcp4921_spi_tx #(.CLK_DIV(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1),
        .dac_cs_pin(cs_w[1]), .dac_clk_pin(sck_w[1]), .dac_mosi_pin(mosi_w[1]), .dac_ldac_pin(ldac_w[1]));
    mcp4921_spi_tx #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2),
        .dac_cs_pin(cs_w[2]), .dac_clk_pin(sck_w[2]), .dac_mosi_pin(mosi_w[2]), .dac_ldac_pin(ldac_w[2]));

    // ------------------------------------------------------------------
    // Pin monitor: one sample per clk cycle, taken at negedge.
    // ------------------------------------------------------------------
    int          rises     [3] = '{0, 0, 0};
    int          done_cnt  [3] = '{0, 0, 0};
    int          sck_cs_hi [3] = '{0, 0, 0};
    int          ldac_act  [3] = '{0, 0, 0};
    int          run_bad   [3] = '{0, 0, 0};
    int          run       [3] = '{0, 0, 0};
    logic        lo_valid  [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] word      [3] = '{16'h0, 16'h0, 16'h0};
    logic [2:0]  sck_q = 3'b000;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (sck_w[i] && !sck_q[i]) begin
                rises[i]++;
                word[i] = {word[i][14:0], mosi_w[i]};
            end
            if (sck_w[i] && cs_w[i])       sck_cs_hi[i]++;
            if (done_w[i])                 done_cnt[i]++;
            if (ldac_w[i] !== LDAC_IDLE)   ldac_act[i]++;
            if (sck_w[i] != sck_q[i]) begin
                if (sck_q[i] && run[i] != DIVS[i])                 run_bad[i]++;
                if (!sck_q[i] && lo_valid[i] && run[i] != DIVS[i]) run_bad[i]++;
                lo_valid[i] = sck_q[i];
                run[i] = 1;
            end else begin
                run[i]++;
            end
            if (cs_w[i]) lo_valid[i] = 1'b0;
            sck_q[i] = sck_w[i];
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic kick(input int i, input logic [3:0] c, input logic [11:0] d);
        cfg_v[i]   = c;
        data_v[i]  = d;
        start_v[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    // lat counts cycles after the accept edge; 1 = first cycle after it.
    task automatic wait_done(input int i, output int lat);
        lat = 1;
        while (!done_w[i] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, r0, d0, t, cs_first, ldac_first, lows, guard;

    initial begin
        // ---------------- reset with start held high ----------------
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs",    32'(cs_w),    32'h7);
        chk("rst_sck",   32'(sck_w),   32'h0);
        chk("rst_mosi",  32'(mosi_w),  32'h0);
        chk("rst_busy",  32'(busy_w),  32'h0);
        chk("rst_done",  32'(done_w),  32'h0);
        chk("rst_ldac",  32'(ldac_w),  LDAC_IDLE ? 32'h7 : 32'h0);
        chk("rst_rises", 32'(rises[0] + rises[1] + rises[2]), 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        start_v = 3'b000;
        repeat (2) @(negedge clk);

        // ---------------- single frame, CLK_DIV=1 ----------------
        r0 = rises[0]; d0 = done_cnt[0];
        kick(0, 4'b0011, 12'hA5C);
        wait_done(0, lat);
        #1;
        chk("d1_latency", 32'(lat), 32'(1 + LAT_K * 1));
        chk("d1_word",    32'(word[0]), 32'h3A5C);
        chk("d1_rises",   32'(rises[0] - r0), 32'd16);
        chk("d1_done",    32'(done_cnt[0] - d0), 32'd1);
        chk("d1_busy_in_done_cycle", 32'(busy_w[0]), 32'd0);

        // ---------------- single frame, CLK_DIV=4 ----------------
        @(negedge clk);
        r0 = rises[1];
        kick(1, 4'b0111, 12'hFFF);
        wait_done(1, lat);
        #1;
        chk("d4_latency", 32'(lat), 32'(1 + LAT_K * 4));
        chk("d4_word",    32'(word[1]), 32'h7FFF);
        chk("d4_rises",   32'(rises[1] - r0), 32'd16);
        chk("d4_sck_phase_len", 32'(run_bad[1]), 32'd0);

        // ---------------- start while busy is ignored ----------------
        @(negedge clk);
        r0 = rises[0]; d0 = done_cnt[0];
        kick(0, 4'b1000, 12'h123);
        repeat (9) @(negedge clk);
        cfg_v[0] = 4'b0011; data_v[0] = 12'h001; start_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, lat);
        repeat (60) @(negedge clk);
        #1;
        chk("busy_start_done", 32'(done_cnt[0] - d0), 32'd1);
        chk("busy_start_rises", 32'(rises[0] - r0), 32'd16);
        chk("busy_start_word",  32'(word[0]), 32'h8123);

        // ---------------- back-to-back via start in the done cycle ----------------
        @(negedge clk);
        r0 = rises[0]; d0 = done_cnt[0];
        kick(0, 4'b0101, 12'h69A);
        wait_done(0, lat);
        kick(0, 4'b1100, 12'h0F0);
        chk("b2b_cs_low",  32'(cs_w[0]), 32'd0);
        chk("b2b_busy",    32'(busy_w[0]), 32'd1);
        wait_done(0, lat);
        #1;
        chk("b2b_latency", 32'(lat), 32'(1 + LAT_K * 1));
        chk("b2b_word",    32'(word[0]), 32'hC0F0);
        chk("b2b_rises",   32'(rises[0] - r0), 32'd32);
        chk("b2b_done",    32'(done_cnt[0] - d0), 32'd2);

        // ---------------- reset mid-frame ----------------
        @(negedge clk);
        r0 = rises[0]; d0 = done_cnt[0];
        kick(0, 4'b0110, 12'h555);
        #1;
        guard = 0;
        while (rises[0] - r0 < 7 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("mid_reached_7_rises", 32'(rises[0] - r0), 32'd7);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_cs",   32'(cs_w[0]),   32'd1);
        chk("mid_rst_sck",  32'(sck_w[0]),  32'd0);
        chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        chk("mid_rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
        @(negedge clk);
        kick(0, 4'b1010, 12'h3C7);
        wait_done(0, lat);
        #1;
        chk("post_rst_latency", 32'(lat), 32'(1 + LAT_K * 1));
        chk("post_rst_word",    32'(word[0]), 32'hA3C7);

        // ---------------- CLK_DIV=2 frame, LDAC timing ----------------
        @(negedge clk);
        r0 = ldac_act[2];
        kick(2, 4'b1111, 12'h000);
        t = 1; cs_first = 0; ldac_first = 0; lows = 0;
        while (!done_w[2] && t < 400) begin
            if (cs_w[2] && cs_first == 0) cs_first = t;
            if (!ldac_w[2]) begin
                lows++;
                if (ldac_first == 0) ldac_first = t;
            end
            @(negedge clk);
            t++;
        end
        #1;
        chk("d2_latency", 32'(t), 32'(1 + LAT_K * 2));
        chk("d2_word",    32'(word[2]), 32'hF000);
`ifdef MCP4921_LDAC_EN
        chk("d2_ldac_low_cycles", 32'(lows), 32'd2);
        chk("d2_ldac_after_cs",   32'(ldac_first - cs_first), 32'd2);
        chk("d2_ldac_act_cnt",    32'(ldac_act[2] - r0), 32'd2);
`else
        chk("ldac_tied_low", 32'(ldac_act[0] + ldac_act[1] + ldac_act[2]), 32'd0);
`endif

        chk("sck_with_cs_high", 32'(sck_cs_hi[0] + sck_cs_hi[1] + sck_cs_hi[2]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
